param_counter: RTL

Parametrised up/down counter: the next generation of the training-lab free-running 4-bit counter. Adds configurable width and modulus, an enable-gated prescaler, synchronous clear/load, wrap-or-saturate mode and terminal-count/event flags. Used by the lab designs as a general tick/event counter and as the timebase for LED blinkers and packet-interval timers.

---
 rtl/param_counter_pkg.sv | 15 +
 rtl/param_prescaler.sv | 40 ++++
 rtl/param_counter.sv | 72 +++++++
 3 files changed

// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised counter.
// Imported by the counter top and its prescaler.
package param_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_prescaler.sv
// Enable-gated prescaler: tick on every PRESCALE-th enabled cycle.
// Partial counts survive en=0; clr restarts the division.
module param_prescaler
  import param_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : int'(clog2(PRESCALE));

  generate
    if (PRESCALE == 1) begin : g_none
      logic unused;
      assign unused = &{1'b0, clk, rst_n, clr};
      assign tick = en;
    end else begin : g_pre
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre <= '0;
        end else if (clr) begin
          pre <= '0;
        end else if (en) begin
          pre <= (pre == LAST) ? '0 : pre + PW'(1);
        end
      end

      assign tick = en && (pre == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_counter.sv
// Up/down counter with modulus, prescaler, clear/load,
// wrap-or-saturate boundaries and terminal/event flags.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               PRESCALE = 1,
  parameter int               SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  logic             tick;
  logic [WIDTH-1:0] clamped;

  param_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr | load),
    .tick (tick)
  );

  assign clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign tc = up ? (count == MAX_VAL) : (count == '0);

  // tc doubles as the boundary test, so no step ever overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (load) begin
      count <= clamped;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (tick) begin
      if (!tc) begin
        count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        wrap  <= 1'b0;
        sat   <= 1'b0;
      end else if (SATURATE == MODE_SAT) begin
        wrap  <= 1'b0;
        sat   <= 1'b1;
      end else begin
        count <= up ? '0 : MAX_VAL;
        wrap  <= 1'b1;
        sat   <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
